// File: rtl/sram_pkg.sv
// sram_pkg: types and default constants shared by the SRAM access sequencer,
// its bus interface and the optional behavioural array model.
//   state_t      - sequencer phase state
//   *_DFLT       - default address/data widths and phase lengths
//   max3()       - helper used to size the phase timer
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    ACCESS    = 2'd2,
    SENSE     = 2'd3
  } state_t;

  localparam int ADDR_W_DFLT    = 10;
  localparam int DATA_W_DFLT    = 4;
  localparam int PRE_CYC_DFLT   = 1;
  localparam int WL_CYC_DFLT    = 2;
  localparam int SENSE_CYC_DFLT = 1;
  localparam int BURST_W_DFLT   = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_seq_ctrl_if.sv
// sram_seq_ctrl_if: request/response bus of the SRAM sequencer.
//   req_valid/req_ready handshake with req_rnw, req_addr, req_wdata, req_burst
//   rsp_valid pulse per beat with rsp_last and rsp_rdata
// Modports: master (pad wrapper / requester), slave (sequencer).
interface sram_seq_ctrl_if
  import sram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int BURST_W = BURST_W_DFLT
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_rnw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BURST_W-1:0] req_burst;
  logic              rsp_valid;
  logic              rsp_last;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_rnw, req_addr, req_wdata, req_burst,
    input  req_ready, rsp_valid, rsp_last, rsp_rdata
  );

  modport slave (
    input  req_valid, req_rnw, req_addr, req_wdata, req_burst,
    output req_ready, rsp_valid, rsp_last, rsp_rdata
  );

endinterface

// File: rtl/sram_array_model.sv
// sram_array_model: behavioural 2^ADDR_W x DATA_W bitcell array used in place
// of the analog array when SRAM_ARRAY_MODEL_EN is defined.
//   clk, wl_en, we, wl_addr, bl_wdata - write port (word written on clk edge)
//   sense_en                          - read enable
//   sense_data                        - mem[wl_addr] while sense_en, else 0
// Contents are deliberately not reset, like the real array.
module sram_array_model
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              wl_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] wl_addr,
  input  logic [DATA_W-1:0] bl_wdata,
  input  logic              sense_en,
  output logic [DATA_W-1:0] sense_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wl_en && we) begin
      mem[wl_addr] <= bl_wdata;
    end
  end

  assign sense_data = sense_en ? mem[wl_addr] : '0;

endmodule

// File: rtl/sram_seq_ctrl.sv
// sram_seq_ctrl: turns a valid/ready request into a timed precharge ->
// wordline -> sense sequence on the analog array pins; reads may burst with
// an auto-incrementing (wrapping) address.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   bus (slave)         - req_* handshake in, rsp_* beat responses out
//   busy                - sequencer not idle
//   pre_en, wl_en, we   - phase enables to the array
//   wl_addr, bl_wdata   - array address / write data
//   sense_en            - sense-amp enable
//   sense_data          - sense-amp outputs (unused when the model is built in)
// Build option: SRAM_ARRAY_MODEL_EN instantiates sram_array_model and reads
// from it instead of the sense_data port.
//
// state     | meaning
// IDLE      | ready for a request
// PRECHARGE | bitline precharge, PRE_CYC cycles
// ACCESS    | wordline (and write drive) on, WL_CYC cycles
// SENSE     | wordline + sense amp on, SENSE_CYC cycles, read beat captured
module sram_seq_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DFLT,
  parameter int DATA_W    = DATA_W_DFLT,
  parameter int PRE_CYC   = PRE_CYC_DFLT,
  parameter int WL_CYC    = WL_CYC_DFLT,
  parameter int SENSE_CYC = SENSE_CYC_DFLT,
  parameter int BURST_W   = BURST_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_seq_ctrl_if.slave    bus,
  output logic              busy,
  output logic              pre_en,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              we,
  output logic [DATA_W-1:0] bl_wdata,
  output logic              sense_en,
  input  logic [DATA_W-1:0] sense_data
);

  localparam int TMR_MAX = max3(PRE_CYC, WL_CYC, SENSE_CYC);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int BEAT_W  = BURST_W + 1;

  // Timer is loaded with length-1 and the phase ends when it reaches zero.
  localparam logic [TMR_W-1:0] PRE_LD   = TMR_W'(PRE_CYC - 1);
  localparam logic [TMR_W-1:0] WL_LD    = TMR_W'(WL_CYC - 1);
  localparam logic [TMR_W-1:0] SENSE_LD = TMR_W'(SENSE_CYC - 1);

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rnw_q, rnw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   sense_sel;
  logic                tmr_done;

`ifdef SRAM_ARRAY_MODEL_EN
  logic [DATA_W-1:0] model_data;

  sram_array_model #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk        (clk),
    .wl_en      (wl_en),
    .we         (we),
    .wl_addr    (wl_addr),
    .bl_wdata   (bl_wdata),
    .sense_en   (sense_en),
    .sense_data (model_data)
  );

  // The external port is masked off but kept referenced.
  assign sense_sel = model_data | (sense_data & {DATA_W{1'b0}});
`else
  assign sense_sel = sense_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      addr_q      <= '0;
      rnw_q       <= 1'b0;
      wdata_q     <= '0;
      beats_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      addr_q      <= addr_d;
      rnw_q       <= rnw_d;
      wdata_q     <= wdata_d;
      beats_q     <= beats_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rdata_q     <= rdata_d;
    end
  end

  assign tmr_done = (tmr_q == '0);

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    addr_d      = addr_q;
    rnw_d       = rnw_q;
    wdata_d     = wdata_q;
    beats_d     = beats_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = PRECHARGE;
          tmr_d   = PRE_LD;
          addr_d  = bus.req_addr;
          rnw_d   = bus.req_rnw;
          wdata_d = bus.req_wdata;
          beats_d = bus.req_rnw ? (BEAT_W'(bus.req_burst) + BEAT_W'(1)) : BEAT_W'(1);
        end
      end
      PRECHARGE: begin
        if (tmr_done) begin
          state_d = ACCESS;
          tmr_d   = WL_LD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ACCESS: begin
        if (tmr_done) begin
          if (rnw_q) begin
            state_d = SENSE;
            tmr_d   = SENSE_LD;
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      SENSE: begin
        if (tmr_done) begin
          rdata_d     = sense_sel;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (beats_q == BEAT_W'(1));
          if (beats_q == BEAT_W'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = PRECHARGE;
            tmr_d   = PRE_LD;
            beats_d = beats_q - BEAT_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase enables decode straight from the state register so an async reset
  // drops them without waiting for a clock.
  assign bus.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign pre_en        = (state_q == PRECHARGE);
  assign wl_en         = (state_q == ACCESS) || (state_q == SENSE);
  assign sense_en      = (state_q == SENSE);
  assign we            = (state_q == ACCESS) && !rnw_q;
  assign wl_addr       = addr_q;
  assign bl_wdata      = we ? wdata_q : '0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// tb_sram_seq_ctrl: randomized scoreboard bench for sram_seq_ctrl.
// A stand-in array drives sense_data so the bench works with or without
// SRAM_ARRAY_MODEL_EN. At each accept the bench derives, from the request
// alone, the expected per-cycle phase outputs and the expected responses;
// a negedge monitor compares the DUT against them.
module tb_sram_seq_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;
  localparam int PRE = 1;
  localparam int WL = 2;
  localparam int SNS = 1;
  localparam int BURST_W = 2;
  localparam int T = PRE + WL + SNS;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int W0 = 'h3F8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, pre_en, wl_en, we, sense_en;
  logic [ADDR_W-1:0] wl_addr;
  logic [DATA_W-1:0] bl_wdata, sense_data;

  sram_seq_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus_if ();

  sram_seq_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRE_CYC(PRE), .WL_CYC(WL),
    .SENSE_CYC(SNS), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .busy(busy), .pre_en(pre_en),
    .wl_en(wl_en), .wl_addr(wl_addr), .we(we), .bl_wdata(bl_wdata),
    .sense_en(sense_en), .sense_data(sense_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the analog array.
  logic [DATA_W-1:0] arr [DEPTH];
  always @(posedge clk) if (wl_en && we) arr[wl_addr] <= bl_wdata;
  assign sense_data = sense_en ? arr[wl_addr] : '0;

  typedef struct packed {
    bit pre; bit wl; bit sense; bit wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } ph_t;
  typedef struct {
    int cyc; logic [DATA_W-1:0] data; bit last; bit rd;
  } rsp_t;

  ph_t ph_map [int];
  rsp_t rsp_q [$];
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] held = '0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_rsp_cyc = -1;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input bit rnw, input int addr, input logic [DATA_W-1:0] wd,
                          input int burst, input int acc);
    ph_t p;
    rsp_t r;
    int a;
    if (!rnw) begin
      ref_mem[addr] = wd;
      for (int k = 0; k < PRE + WL; k++) begin
        p = '0;
        p.pre = (k < PRE);
        p.wl = !p.pre;
        p.wr = p.wl;
        p.addr = ADDR_W'(addr);
        p.wd = wd;
        ph_map[acc + k] = p;
      end
      r.cyc = acc + PRE + WL; r.data = '0; r.last = 1'b1; r.rd = 1'b0;
      rsp_q.push_back(r);
      last_rsp_cyc = r.cyc;
    end else begin
      for (int b = 0; b <= burst; b++) begin
        a = (addr + b) % DEPTH;
        for (int k = 0; k < T; k++) begin
          p = '0;
          p.pre = (k < PRE);
          p.wl = !p.pre;
          p.sense = (k >= PRE + WL);
          p.addr = ADDR_W'(a);
          ph_map[acc + b * T + k] = p;
        end
        r.cyc = acc + (b + 1) * T; r.data = ref_mem[a]; r.last = (b == burst); r.rd = 1'b1;
        rsp_q.push_back(r);
        last_rsp_cyc = r.cyc;
      end
    end
  endtask

  // Waits for req_ready (scrambling req_* while busy), then issues one request.
  task automatic issue(input bit rnw, input int addr, input logic [DATA_W-1:0] wd,
                       input int burst, input bit chk_b2b);
    int n;
    int acc;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus_if.req_ready === 1'b1) break;
      bus_if.req_valid = 1'($urandom);
      bus_if.req_rnw = 1'($urandom);
      bus_if.req_addr = ADDR_W'($urandom);
      bus_if.req_wdata = DATA_W'($urandom);
      bus_if.req_burst = BURST_W'($urandom);
      n++;
      if (n > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: req_ready still %b after 200 cycles, required 1", bus_if.req_ready);
        bus_if.req_valid = 1'b0;
        return;
      end
    end
    bus_if.req_valid = 1'b1;
    bus_if.req_rnw = rnw;
    bus_if.req_addr = ADDR_W'(addr);
    bus_if.req_wdata = wd;
    bus_if.req_burst = BURST_W'(burst);
    acc = cyc + 1;
    if (chk_b2b) begin
      n_cmp++;
      if (acc - 1 != last_rsp_cyc) begin
        n_bad++;
        $display("FAIL b2b_accept: accept in cycle %0d, required response cycle %0d", acc - 1, last_rsp_cyc);
      end
    end
    push_exp(rnw, addr, wd, burst, acc);
    last_acc = acc;
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
  endtask

  // Monitor: phase timeline, handshake flags and responses.
  always @(negedge clk) begin : mon
    ph_t e;
    bit in_map;
    rsp_t r;
    in_map = ph_map.exists(cyc);
    e = in_map ? ph_map[cyc] : '0;
    n_cmp++;
    if ({busy, bus_if.req_ready, pre_en, wl_en, sense_en, we} !==
        {in_map, !in_map, e.pre, e.wl, e.sense, e.wr}) begin
      n_bad++;
      $display("FAIL phase cyc=%0d: busy/ready/pre/wl/sense/we=%b required %b", cyc,
               {busy, bus_if.req_ready, pre_en, wl_en, sense_en, we},
               {in_map, !in_map, e.pre, e.wl, e.sense, e.wr});
    end
    if (in_map && e.wl) begin
      n_cmp++;
      if (wl_addr !== e.addr) begin
        n_bad++;
        $display("FAIL wl_addr cyc=%0d: got %h required %h", cyc, wl_addr, e.addr);
      end
    end
    if (in_map && e.wr) begin
      n_cmp++;
      if (bl_wdata !== e.wd) begin
        n_bad++;
        $display("FAIL bl_wdata cyc=%0d: got %h required %h", cyc, bl_wdata, e.wd);
      end
    end
    if (bus_if.rsp_valid === 1'b1) begin
      n_cmp++;
      if (rsp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp cyc=%0d: rsp_valid 1 required 0", cyc);
      end else begin
        r = rsp_q.pop_front();
        if (r.rd) held = r.data;
        if (r.cyc != cyc || bus_if.rsp_last !== r.last) begin
          n_bad++;
          $display("FAIL rsp_timing: cyc=%0d last=%b required cyc=%0d last=%b",
                   cyc, bus_if.rsp_last, r.cyc, r.last);
        end
      end
    end else if (bus_if.rsp_valid !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_valid_x cyc=%0d: got %b required 0/1", cyc, bus_if.rsp_valid);
    end else if (rsp_q.size() != 0 && rsp_q[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL missed_rsp: rsp_valid still 0 at cyc=%0d, required at cyc=%0d", cyc, rsp_q[0].cyc);
      void'(rsp_q.pop_front());
    end
    n_cmp++;
    if (bus_if.rsp_rdata !== held) begin
      n_bad++;
      $display("FAIL rsp_rdata cyc=%0d: got %h required %h", cyc, bus_if.rsp_rdata, held);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, a, gap, n;
    logic [DATA_W-1:0] d;
    bus_if.req_valid = 1'b0;
    bus_if.req_rnw = 1'b0;
    bus_if.req_addr = '0;
    bus_if.req_wdata = '0;
    bus_if.req_burst = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus_if.rsp_last, wl_addr, bl_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: rsp_last/wl_addr/bl_wdata=%h required 0",
               {bus_if.rsp_last, wl_addr, bl_wdata});
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Write then read one word.
    issue(1'b0, 'h155, 4'hA, 0, 1'b0);
    issue(1'b1, 'h155, 4'h0, 0, 1'b1);

    // Preload a window spanning the address wrap, back to back.
    for (int i = 0; i < 32; i++) begin
      a = (W0 + i) % DEPTH;
      case (a)
        'h3FE: d = 4'd1;
        'h3FF: d = 4'd2;
        'h000: d = 4'd3;
        'h001: d = 4'd4;
        default: d = DATA_W'($urandom);
      endcase
      issue(1'b0, a, d, 0, i > 0);
    end

    // Wrapping 4-beat burst.
    issue(1'b1, 'h3FE, 4'h0, 3, 1'b1);

    // Reset during beat 2 of a 4-beat burst.
    issue(1'b1, 'h3FE, 4'h0, 3, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (cyc < last_acc + T + 1 && n < 100);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, pre_en, wl_en, sense_en, we, bus_if.rsp_valid, bus_if.req_ready, bus_if.rsp_rdata} !==
        {7'b0000001, {DATA_W{1'b0}}}) begin
      n_bad++;
      $display("FAIL mid_reset: busy/pre/wl/sense/we/rsp_valid/ready/rdata=%b required %b",
               {busy, pre_en, wl_en, sense_en, we, bus_if.rsp_valid, bus_if.req_ready, bus_if.rsp_rdata},
               {7'b0000001, {DATA_W{1'b0}}});
    end
    rsp_q.delete();
    ph_map.delete();
    held = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(1'b1, 'h3FE, 4'h0, 0, 1'b0);

    // Back-to-back alternating write/read on one address.
    for (int i = 0; i < 6; i++) begin
      issue(i % 2 == 1, 'h010, DATA_W'($urandom), 0, 1'b1);
    end

    // Random traffic inside the preloaded window.
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom_range(0, 28);
        issue(1'b1, (W0 + w) % DEPTH, 4'h0, $urandom_range(0, 3), gap == 0);
      end else begin
        w = $urandom_range(0, 31);
        issue(1'b0, (W0 + w) % DEPTH, DATA_W'($urandom), 0, gap == 0);
      end
    end

    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rsp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", rsp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
